fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the core, directly upstream of decode. It owns the PC and fetches 32-bit instructions from IMEM over an APB master port, one transfer outstanding, into a single-entry output buffer handed to ID with a valid/ready handshake. It stalls sequential fetch after any control-flow instruction. It resumes on the branch comparator result from the execute/mem/writeback stage, or on a jump redirect from ID.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- ADDR_W, 32: PC/APB address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_apb  apb_if.master  -  IMEM APB port; uses paddr, psel, penable, pwrite (tied 0), prdata, pready, pslverr.
- ready_i  in  1  ID accepts instr_o/pc_o this cycle.
- valid_o  out  1  instr_o/pc_o hold a fetched instruction.
- instr_o  out  32  fetched instruction word.
- pc_o  out  ADDR_W  address of instr_o.
- redirect_valid_i  in  1  ID resolved JAL/JALR or branch target is on redirect_pc_i.
- redirect_pc_i  in  ADDR_W  jump target, or branch target when taken.
- cmp_result_valid_i  in  1  branch comparator result valid (from execute).
- cmp_result_i  in  1  1 = branch taken.
- err_o  out  1  sticky fetch fault (pslverr or misaligned target).

## Operation
- States: IDLE, SETUP, ACCESS, WAIT_CF, ERR.
- IDLE: when the buffer is free or draining (!valid_o || ready_i), go to SETUP with paddr=pc.
- SETUP: psel=1, penable=0; always go to ACCESS.
- ACCESS: psel=1, penable=1; stay while pready=0.
- ACCESS completion, pready=1 and pslverr=0:
  - instr_o<=prdata, pc_o<=pc, valid_o<=1, pc<=pc+4 (wraps mod 2^ADDR_W).
  - Predecode prdata[6:0]: 1100011 (BRANCH), 1101111 (JAL) or 1100111 (JALR) go to WAIT_CF; anything else goes to IDLE.
- ACCESS with pready=1 and pslverr=1: no capture, err_o<=1, go to ERR.
- WAIT_CF: no fetch issued.
  - redirect_valid_i=1 for JAL/JALR: pc<=redirect_pc_i, go to IDLE.
  - cmp_result_valid_i=1 for BRANCH: taken sets pc<=redirect_pc_i (ID holds the target valid alongside); not taken keeps pc (already branch+4). Then go to IDLE.
  - If both arrive in the same cycle, cmp_result_valid_i governs a BRANCH and redirect_valid_i governs a JAL/JALR. The predecoded class is stored in a 2-bit register.
  - Target with [1:0]!=0: err_o<=1, go to ERR.
- ERR: psel=0, valid_o still drains normally, no further fetch. Exit only by reset.
- Buffer: valid_o clears on valid_o&&ready_i unless a capture happens the same edge. Capture needs a free buffer, which IDLE's issue condition guarantees. One outstanding transfer, no overflow possible.
- redirect/cmp inputs outside WAIT_CF are ignored.

## Timing
- Reset values: valid_o=0, instr_o=0, pc_o=0, err_o=0, psel=0, penable=0, paddr=RESET_PC, state=IDLE, pc=RESET_PC.
- Reset mid-transfer: psel/penable drop asynchronously, and the transfer is abandoned.
- Latency with zero-wait IMEM:
  - IDLE at cycle 0 gives SETUP at 1, ACCESS at 2, valid_o at 3.
  - Steady state with ready_i=1 throughout: one instruction every 3 cycles. IDLE issues in the same cycle valid_o is consumed, so there is no added bubble.
  - Each pready=0 cycle adds one cycle.
- paddr, psel and pwrite are stable from SETUP through ACCESS completion (APB rule).
- Redirect/cmp sampled in WAIT_CF at edge N: SETUP at N+1 with the new paddr.
- instr_o/pc_o are held stable while valid_o&&!ready_i.

## Structure
- typedefs package: fetch_state_e; opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR; cf_kind_e {CF_NONE, CF_BRANCH, CF_JUMP}.
- Single module. Predecode is a 7-bit compare inline; no sub-module is warranted. Reuse the existing apb_if.

## Test plan
- Reset, IMEM always ready, ready_i=1, NOPs at 0x0/0x4/0x8 -> valid_o first at cycle 3; pc_o=0x0, 0x4, 0x8 every 3 cycles; pwrite=0.
- ID stalls (ready_i=0 for 5 cycles) with instr at 0x4 captured -> instr_o/pc_o=0x4 held; no psel until ready_i=1; next paddr=0x8.
- BEQ at 0x10, cmp_result_valid_i=1, cmp_result_i=1, redirect_pc_i=0x40 -> no fetch during WAIT_CF; next paddr=0x40. Repeat with cmp_result_i=0 -> next paddr=0x14.
- JAL at 0x20, redirect_valid_i=1, redirect_pc_i=0x100 after 4 cycles -> next paddr=0x100; stray cmp_result_valid_i pulses ignored.
- pready=0 for 3 cycles, then pslverr=1 at 0x8 -> no capture, err_o=1, psel stays 0 afterwards; redirect_pc_i=0x42 in another run -> err_o=1.
- rst_n asserted mid-ACCESS -> psel/penable=0 immediately; after release, first paddr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    // Fetch sequencer states. SETUP/ACCESS are the two APB phases of a read.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        WAIT_CF = 3'd3,
        ERR     = 3'd4
    } fetch_state_e;

    // Class of the last fetched instruction, as far as fetch cares.
    // BRANCH resumes on the comparator result, JUMP on the ID redirect.
    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JUMP   = 2'd2
    } cf_kind_e;

    // RV32 major opcodes that change control flow.
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/apb_if.sv
// Minimal APB read/write bus shared by the core's memory ports.
interface apb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads one instruction at a time from
// IMEM over APB and presents it to decode through a single-entry buffer.
// Sequential fetch pauses after any branch/jump until execute (branch
// outcome) or decode (jump target) tells us where to continue.
//
// Handshake to ID: valid_o/instr_o/pc_o form a valid/ready channel. A word
// transfers on a rising edge where valid_o && ready_i. While valid_o is high
// and ready_i is low, instr_o and pc_o do not change. valid_o never drops
// without a transfer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    apb_if.master             imem_apb,

    input  logic              ready_i,
    output logic              valid_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,

    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              cmp_result_valid_i,
    input  logic              cmp_result_i,

    output logic              err_o
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    cf_kind_e          cf_kind_q, cf_kind_d;

    // ------------------------------------------------------------------
    // Decision signals
    // ------------------------------------------------------------------
    logic              buf_free;          // buffer empty, or emptying this edge
    cf_kind_e          fetched_kind;      // predecode of the word on prdata
    logic              cf_resolved;       // awaited resume event is present
    logic [ADDR_W-1:0] cf_target;         // where fetch resumes once resolved
    logic              target_misaligned;

    // Strobes derived from the current state (output process)
    logic              issue;             // IDLE -> SETUP, latch paddr
    logic              capture;           // good read completes, fill buffer
    logic              bus_fault;         // read completes with pslverr
    logic              cf_redirect;       // resume fetch at cf_target
    logic              cf_fault;          // resume target not word aligned

    assign buf_free = !valid_q || ready_i;

    // Predecode of the returned word: only the 7-bit major opcode matters.
    always_comb begin
        fetched_kind = CF_NONE;
        if (imem_apb.prdata[6:0] == OPC_BRANCH) begin
            fetched_kind = CF_BRANCH;
        end else if ((imem_apb.prdata[6:0] == OPC_JAL) ||
                     (imem_apb.prdata[6:0] == OPC_JALR)) begin
            fetched_kind = CF_JUMP;
        end
    end

    // Resume event selection: the stored class decides which input counts,
    // so a simultaneous pulse on the other input is ignored. A not-taken
    // branch keeps pc, which already points past the branch.
    always_comb begin
        cf_resolved = 1'b0;
        cf_target   = pc_q;
        case (cf_kind_q)
            CF_BRANCH: begin
                if (cmp_result_valid_i) begin
                    cf_resolved = 1'b1;
                    if (cmp_result_i) begin
                        cf_target = redirect_pc_i;
                    end
                end
            end
            CF_JUMP: begin
                if (redirect_valid_i) begin
                    cf_resolved = 1'b1;
                    cf_target   = redirect_pc_i;
                end
            end
            default: begin
                cf_resolved = 1'b0;
            end
        endcase
    end

    assign target_misaligned = (cf_target[1:0] != 2'b00);

    // ------------------------------------------------------------------
    // FSM: state register (async reset drops psel/penable immediately,
    // abandoning any transfer in flight)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (buf_free) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (imem_apb.pready) begin
                    if (imem_apb.pslverr) begin
                        state_d = ERR;
                    end else if (fetched_kind != CF_NONE) begin
                        state_d = WAIT_CF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_CF: begin
                if (cf_resolved) begin
                    state_d = target_misaligned ? ERR : IDLE;
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM: outputs and per-state strobes
    always_comb begin
        imem_apb.psel    = 1'b0;
        imem_apb.penable = 1'b0;
        imem_apb.pwrite  = 1'b0;
        imem_apb.paddr   = paddr_q;
        issue            = 1'b0;
        capture          = 1'b0;
        bus_fault        = 1'b0;
        cf_redirect      = 1'b0;
        cf_fault         = 1'b0;
        unique case (state_q)
            IDLE: begin
                issue = buf_free;
            end
            SETUP: begin
                imem_apb.psel = 1'b1;
            end
            ACCESS: begin
                imem_apb.psel    = 1'b1;
                imem_apb.penable = 1'b1;
                capture          = imem_apb.pready && !imem_apb.pslverr;
                bus_fault        = imem_apb.pready &&  imem_apb.pslverr;
            end
            WAIT_CF: begin
                cf_redirect = cf_resolved && !target_misaligned;
                cf_fault    = cf_resolved &&  target_misaligned;
            end
            ERR: begin
                imem_apb.psel = 1'b0;
            end
            default: begin
                imem_apb.psel = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values: PC, bus address, output buffer, fault flag
    // ------------------------------------------------------------------
    always_comb begin
        pc_d      = pc_q;
        paddr_d   = paddr_q;
        pc_out_d  = pc_out_q;
        instr_d   = instr_q;
        valid_d   = valid_q && !ready_i;
        err_d     = err_q || bus_fault || cf_fault;
        cf_kind_d = cf_kind_q;

        // paddr is latched on issue and held through ACCESS completion
        if (issue) begin
            paddr_d = pc_q;
        end

        // A capture always lands in a free buffer: IDLE only issued when
        // the buffer was empty or draining, and only one read is in flight.
        if (capture) begin
            valid_d   = 1'b1;
            instr_d   = imem_apb.prdata;
            pc_out_d  = pc_q;
            pc_d      = pc_q + ADDR_W'(4);
            cf_kind_d = fetched_kind;
        end else if (cf_redirect) begin
            pc_d      = cf_target;
            cf_kind_d = CF_NONE;
        end else if (cf_fault) begin
            cf_kind_d = CF_NONE;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            paddr_q   <= RESET_PC;
            pc_out_q  <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            cf_kind_q <= CF_NONE;
        end else begin
            pc_q      <= pc_d;
            paddr_q   <= paddr_d;
            pc_out_q  <= pc_out_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            cf_kind_q <= cf_kind_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_out_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations plus
// randomized runs, all watched every cycle by a transaction-level model.
module tb_fetch_stage;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT I/O ----------------
  logic        ready_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        cmp_result_valid_i = 1'b0;
  logic        cmp_result_i = 1'b0;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        err_o;

  // IMEM slave: word array, response controls driven by the bench
  logic [31:0] mem [0:255];
  logic        slv_ready = 1'b1;
  logic        slv_err = 1'b0;

  apb_if #(.ADDR_W(ADDR_W), .DATA_W(32)) imem_apb ();
  assign imem_apb.pready  = slv_ready;
  assign imem_apb.pslverr = slv_err;
  assign imem_apb.prdata  = mem[imem_apb.paddr[9:2]];

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem_apb           (imem_apb),
    .ready_i            (ready_i),
    .valid_o            (valid_o),
    .instr_o            (instr_o),
    .pc_o               (pc_o),
    .redirect_valid_i   (redirect_valid_i),
    .redirect_pc_i      (redirect_pc_i),
    .cmp_result_valid_i (cmp_result_valid_i),
    .cmp_result_i       (cmp_result_i),
    .err_o              (err_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [31:0] w);
    if (w[6:0] == 7'h63) return 1;                      // branch
    if (w[6:0] == 7'h6f || w[6:0] == 7'h67) return 2;   // jal / jalr
    return 0;
  endfunction

  // ---------------- reference model + scoreboard ----------------
  // Tracks: the PC fetch must use next, whether a read is in its setup or
  // access phase, whether fetch is parked behind a control-flow instruction,
  // the sticky fault, and the instructions owed to ID (exp_q = {pc, instr}).
  logic [31:0] m_pc;
  logic        m_err;
  logic        m_busy;
  logic        m_setup_due;
  int          m_wait;
  logic [63:0] exp_q[$];

  always @(negedge clk) begin : compare
    logic        in_setup, in_access, resting, nxt_setup, resolved;
    logic [31:0] tgt, word;
    if (!rst_n) begin
      m_pc = RESET_PC; m_err = 1'b0; m_busy = 1'b0; m_setup_due = 1'b0; m_wait = 0;
      exp_q.delete();
    end else begin
      in_setup  = m_setup_due;
      in_access = m_busy;
      resting   = !in_setup && !in_access && (m_wait == 0) && !m_err;

      check("valid_o", {31'd0, valid_o}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("pc_o", pc_o, exp_q[0][63:32]);
        check("instr_o", instr_o, exp_q[0][31:0]);
      end
      check("err_o", {31'd0, err_o}, {31'd0, m_err});
      check("psel", {31'd0, imem_apb.psel}, {31'd0, in_setup || in_access});
      check("penable", {31'd0, imem_apb.penable}, {31'd0, in_access});
      check("pwrite", {31'd0, imem_apb.pwrite}, 32'd0);
      if (in_setup || in_access) check("paddr", imem_apb.paddr, m_pc);

      // a fetch starts the cycle after a resting cycle with room in the buffer
      nxt_setup = resting && (exp_q.size() == 0 || ready_i);
      if (exp_q.size() != 0 && ready_i) void'(exp_q.pop_front());

      if (in_setup) m_busy = 1'b1;
      if (in_access && slv_ready) begin
        m_busy = 1'b0;
        if (slv_err) begin
          m_err = 1'b1;
        end else begin
          word = mem[m_pc[9:2]];
          check("buffer_free_on_capture", exp_q.size(), 32'd0);
          exp_q.push_back({m_pc, word});
          m_wait = kind_of(word);
          m_pc   = m_pc + 32'd4;
        end
      end else if (m_wait != 0) begin
        resolved = 1'b0;
        tgt      = m_pc;
        if (m_wait == 1 && cmp_result_valid_i) begin
          resolved = 1'b1;
          if (cmp_result_i) tgt = redirect_pc_i;
        end
        if (m_wait == 2 && redirect_valid_i) begin
          resolved = 1'b1;
          tgt      = redirect_pc_i;
        end
        if (resolved) begin
          m_wait = 0;
          if (tgt[1:0] != 2'b00) m_err = 1'b1;
          else m_pc = tgt;
        end
      end
      m_setup_due = nxt_setup;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    ready_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    cmp_result_valid_i = 1'b0; cmp_result_i = 1'b0;
    slv_ready = 1'b1; slv_err = 1'b0;
  endtask

  // Leaves the bench at posedge+1 of the first cycle out of reset (IDLE).
  task automatic do_reset();
    rst_n = 1'b0;
    quiet_inputs();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 256; i++) mem[i] = NOP;
  endtask

  task automatic wait_fetch_of(input logic [31:0] addr, input string name);
    int n = 0;
    while (!(valid_o && pc_o == addr) && n < 100) begin
      step(1);
      n++;
    end
    check(name, {31'd0, valid_o && pc_o == addr}, 32'd1);
  endtask

  task automatic wait_setup_of(input logic [31:0] addr, input string name);
    int n = 0;
    while (!(imem_apb.psel && !imem_apb.penable && imem_apb.paddr == addr) && n < 100) begin
      step(1);
      n++;
    end
    check(name, {31'd0, imem_apb.psel && !imem_apb.penable}, 32'd1);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic [31:0] w;
    int          n;

    // 1) reset values and zero-wait throughput
    load_nops();
    quiet_inputs();
    rst_n = 1'b0;
    step(2);
    check("rst_valid_o", {31'd0, valid_o}, 32'd0);
    check("rst_err_o", {31'd0, err_o}, 32'd0);
    check("rst_pc_o", pc_o, 32'd0);
    check("rst_instr_o", instr_o, 32'd0);
    check("rst_psel", {31'd0, imem_apb.psel}, 32'd0);
    check("rst_penable", {31'd0, imem_apb.penable}, 32'd0);
    check("rst_paddr", imem_apb.paddr, RESET_PC);
    ready_i = 1'b1;
    rst_n = 1'b1;                                   // cycle 0, IDLE
    step(1);
    check("c1_setup", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd2);
    check("c1_paddr", imem_apb.paddr, 32'h0);
    step(1);
    check("c2_access", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd3);
    check("c2_no_valid", {31'd0, valid_o}, 32'd0);
    step(1);
    check("c3_valid", {31'd0, valid_o}, 32'd1);
    check("c3_pc", pc_o, 32'h0);
    check("c3_instr", instr_o, NOP);
    step(1);
    check("c4_drained", {31'd0, valid_o}, 32'd0);
    step(2);
    check("c6_pc", pc_o, 32'h4);
    step(3);
    check("c9_pc", pc_o, 32'h8);
    check("pwrite_low", {31'd0, imem_apb.pwrite}, 32'd0);

    // 2) ID stall holds the buffer and blocks the next fetch
    do_reset();
    ready_i = 1'b1;
    step(6);
    check("stall_pc_captured", pc_o, 32'h4);
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold_pc", pc_o, 32'h4);
      check("stall_hold_valid", {31'd0, valid_o}, 32'd1);
      check("stall_no_psel", {31'd0, imem_apb.psel}, 32'd0);
      step(1);
    end
    ready_i = 1'b1;
    step(1);
    check("stall_resume_setup", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd2);
    check("stall_resume_paddr", imem_apb.paddr, 32'h8);

    // 3) BEQ at 0x10: taken -> 0x40, not taken -> 0x14
    for (int t = 0; t < 2; t++) begin
      load_nops();
      mem[4] = 32'h0020_8463;
      do_reset();
      ready_i = 1'b1;
      wait_fetch_of(32'h10, "beq_fetched");
      for (int i = 0; i < 3; i++) begin
        step(1);
        check("beq_parked_no_psel", {31'd0, imem_apb.psel}, 32'd0);
      end
      cmp_result_valid_i = 1'b1;
      cmp_result_i = (t == 0);
      redirect_pc_i = 32'h40;
      step(1);
      cmp_result_valid_i = 1'b0;
      check("beq_idle_after", {31'd0, imem_apb.psel}, 32'd0);
      step(1);
      check("beq_setup", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd2);
      check("beq_next_paddr", imem_apb.paddr, (t == 0) ? 32'h40 : 32'h14);
    end

    // 4) JAL at 0x20, stray comparator pulses ignored, then redirect to 0x100
    load_nops();
    mem[8] = 32'h1000_006f;
    do_reset();
    ready_i = 1'b1;
    wait_fetch_of(32'h20, "jal_fetched");
    for (int i = 0; i < 4; i++) begin
      cmp_result_valid_i = i[0];
      cmp_result_i = 1'b1;
      redirect_pc_i = 32'h80;
      step(1);
      check("jal_parked_no_psel", {31'd0, imem_apb.psel}, 32'd0);
    end
    cmp_result_valid_i = 1'b0;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h100;
    step(1);
    redirect_valid_i = 1'b0;
    step(1);
    check("jal_setup", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd2);
    check("jal_next_paddr", imem_apb.paddr, 32'h100);

    // 5a) three wait states then a slave error at 0x8
    load_nops();
    do_reset();
    ready_i = 1'b1;
    wait_setup_of(32'h8, "err_setup_seen");
    slv_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("err_access_held", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd3);
      check("err_paddr_stable", imem_apb.paddr, 32'h8);
      check("err_not_yet", {31'd0, err_o}, 32'd0);
    end
    slv_ready = 1'b1;
    slv_err = 1'b1;
    step(1);
    slv_err = 1'b0;
    check("err_sticky_set", {31'd0, err_o}, 32'd1);
    check("err_no_capture", {31'd0, valid_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("err_no_psel", {31'd0, imem_apb.psel}, 32'd0);
      check("err_still_set", {31'd0, err_o}, 32'd1);
    end

    // 5b) misaligned jump target
    load_nops();
    mem[0] = 32'h0000_006f;
    do_reset();
    ready_i = 1'b1;
    wait_fetch_of(32'h0, "mis_jal_fetched");
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h42;
    step(1);
    redirect_valid_i = 1'b0;
    check("mis_err", {31'd0, err_o}, 32'd1);
    step(3);
    check("mis_no_psel", {31'd0, imem_apb.psel}, 32'd0);

    // 6) reset in the middle of an access
    load_nops();
    do_reset();
    ready_i = 1'b1;
    slv_ready = 1'b0;
    n = 0;
    while (!(imem_apb.psel && imem_apb.penable) && n < 20) begin
      step(1);
      n++;
    end
    check("rstmid_in_access", {31'd0, imem_apb.penable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_psel_drop", {31'd0, imem_apb.psel}, 32'd0);
    check("rstmid_penable_drop", {31'd0, imem_apb.penable}, 32'd0);
    slv_ready = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(1);
    check("rstmid_first_paddr", imem_apb.paddr, RESET_PC);
    check("rstmid_first_setup", {30'd0, imem_apb.psel, imem_apb.penable}, 32'd2);

    // 7) randomized runs against the model
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) begin
        w = $urandom;
        case ($urandom_range(0, 5))
          0, 1:    w[6:0] = 7'h13;
          2:       w[6:0] = 7'h33;
          3:       w[6:0] = 7'h63;
          4:       w[6:0] = 7'h6f;
          default: w[6:0] = 7'h67;
        endcase
        mem[i] = w;
      end
      do_reset();
      for (int c = 0; c < 500; c++) begin
        ready_i            = ($urandom_range(0, 3) != 0);
        slv_ready          = ($urandom_range(0, 3) != 0);
        slv_err            = ($urandom_range(0, 399) == 0);
        redirect_valid_i   = ($urandom_range(0, 2) == 0);
        cmp_result_valid_i = ($urandom_range(0, 2) == 0);
        cmp_result_i       = $urandom_range(0, 1) != 0;
        redirect_pc_i      = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        if ($urandom_range(0, 299) == 0) redirect_pc_i[1:0] = 2'($urandom_range(1, 3));
        step(1);
      end
    end

    quiet_inputs();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
